// File: rtl/tsal_spi_if.sv
// SPI bus between the TSAL monitor and its ADCs.
// One shared cs/s_clk pair and one data line per ADC.
interface tsal_spi_if #(
    parameter int CHANNELS = 2
);
    logic                s_clk;
    logic                cs;
    logic [CHANNELS-1:0] s_data;

    modport master (output s_clk, output cs, input s_data);
    modport slave  (input s_clk, input cs, output s_data);
endinterface

// File: rtl/tsal_spi_monitor.sv
// TSAL monitor: clocks CHANNELS SPI ADCs in lock-step, compares each result
// against a threshold with hysteresis and drives the green/red TSAL lamps.
module tsal_spi_monitor #(
    parameter int ADC_BITS   = 12,
    parameter int FRAME_BITS = 16,
    parameter int CHANNELS   = 2,
    parameter int CLK_DIV    = 2,
    parameter int QUIET_CYC  = 4,
    parameter int HYST       = 16,
    parameter int BLINK_DIV  = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    tsal_spi_if.master                   spi,
    input  logic [ADC_BITS-1:0]          threshold,
    output logic [CHANNELS*ADC_BITS-1:0] sample,
    output logic                         sample_valid,
    output logic                         hv_active,
    output logic                         green_led,
    output logic                         red_led
);
    // state    | meaning
    // ST_QUIET | cs high between frames, counting QUIET_CYC cycles
    // ST_CONV  | cs low, FRAME_BITS SCLK cycles, shifting on SCLK rise
    // ST_DONE  | cs high, commit sample and update HV flags
    typedef enum logic [1:0] {ST_QUIET, ST_CONV, ST_DONE} state_t;

    localparam int DW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(FRAME_BITS + 1);
    localparam int QW = $clog2(QUIET_CYC + 1);
    localparam int LW = $clog2(BLINK_DIV + 1);
    localparam logic [DW-1:0]     DIV_LOAD   = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0]     BIT_LOAD   = BW'(FRAME_BITS - 1);
    localparam logic [QW-1:0]     QUIET_LOAD = QW'(QUIET_CYC - 1);
    localparam logic [LW-1:0]     BLINK_LOAD = LW'(BLINK_DIV - 1);
    localparam logic [ADC_BITS:0] HYST_EXT   = (ADC_BITS + 1)'(HYST);

    state_t                             state_q, state_d;
    logic [QW-1:0]                      quiet_q, quiet_d;
    logic [DW-1:0]                      div_q, div_d;
    logic [BW-1:0]                      bit_q, bit_d;
    logic [LW-1:0]                      blink_q, blink_d;
    logic                               cs_q, cs_d;
    logic                               s_clk_q, s_clk_d;
    logic [CHANNELS-1:0][ADC_BITS-1:0]  shift_q, shift_d;
    logic [CHANNELS-1:0][ADC_BITS-1:0]  sample_q, sample_d;
    logic                               valid_q, valid_d;
    logic [CHANNELS-1:0]                hv_q, hv_d;
    logic                               seen_q, seen_d;
    logic                               green_q, green_d;
    logic                               red_q, red_d;

    always_comb begin
        state_d  = state_q;
        quiet_d  = quiet_q;
        div_d    = div_q;
        bit_d    = bit_q;
        cs_d     = cs_q;
        s_clk_d  = s_clk_q;
        shift_d  = shift_q;
        sample_d = sample_q;
        valid_d  = 1'b0;
        hv_d     = hv_q;
        seen_d   = seen_q;

        case (state_q)
            ST_QUIET: begin
                cs_d    = 1'b1;
                s_clk_d = 1'b1;
                if (quiet_q == '0) begin
                    state_d = ST_CONV;
                    cs_d    = 1'b0;
                    s_clk_d = 1'b0;
                    div_d   = DIV_LOAD;
                    bit_d   = BIT_LOAD;
                end else begin
                    quiet_d = quiet_q - 1'b1;
                end
            end
            ST_CONV: begin
                if (div_q != '0) begin
                    div_d = div_q - 1'b1;
                end else begin
                    div_d = DIV_LOAD;
                    if (!s_clk_q) begin
                        s_clk_d = 1'b1;
                        for (int i = 0; i < CHANNELS; i++) begin
                            shift_d[i] = (shift_q[i] << 1) | ADC_BITS'(spi.s_data[i]);
                        end
                    end else if (bit_q == '0) begin
                        state_d = ST_DONE;
                        cs_d    = 1'b1;
                    end else begin
                        s_clk_d = 1'b0;
                        bit_d   = bit_q - 1'b1;
                    end
                end
            end
            ST_DONE: begin
                sample_d = shift_q;
                valid_d  = 1'b1;
                seen_d   = 1'b1;
                // Sum is one bit wider than the result so it cannot wrap.
                for (int i = 0; i < CHANNELS; i++) begin
                    if (shift_q[i] >= threshold) begin
                        hv_d[i] = 1'b1;
                    end else if (({1'b0, shift_q[i]} + HYST_EXT) < {1'b0, threshold}) begin
                        hv_d[i] = 1'b0;
                    end
                end
                state_d = ST_QUIET;
                quiet_d = QUIET_LOAD;
            end
            default: state_d = ST_QUIET;
        endcase

        // Red lights on the cycle HV first registers, then toggles every BLINK_DIV.
        if (hv_d == '0) begin
            red_d   = 1'b0;
            blink_d = '0;
        end else if (hv_q == '0) begin
            red_d   = 1'b1;
            blink_d = BLINK_LOAD;
        end else if (blink_q == '0) begin
            red_d   = ~red_q;
            blink_d = BLINK_LOAD;
        end else begin
            red_d   = red_q;
            blink_d = blink_q - 1'b1;
        end
        green_d = seen_d & ~(|hv_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_QUIET;
            quiet_q  <= QUIET_LOAD;
            div_q    <= '0;
            bit_q    <= '0;
            blink_q  <= '0;
            cs_q     <= 1'b1;
            s_clk_q  <= 1'b1;
            shift_q  <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
            hv_q     <= '0;
            seen_q   <= 1'b0;
            green_q  <= 1'b0;
            red_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            quiet_q  <= quiet_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            blink_q  <= blink_d;
            cs_q     <= cs_d;
            s_clk_q  <= s_clk_d;
            shift_q  <= shift_d;
            sample_q <= sample_d;
            valid_q  <= valid_d;
            hv_q     <= hv_d;
            seen_q   <= seen_d;
            green_q  <= green_d;
            red_q    <= red_d;
        end
    end

    assign spi.s_clk    = s_clk_q;
    assign spi.cs       = cs_q;
    assign sample       = sample_q;
    assign sample_valid = valid_q;
    assign hv_active    = |hv_q;
    assign green_led    = green_q;
    assign red_led      = red_q;
endmodule

// File: tb/tb_tsal_spi_monitor.sv
// Bench for tsal_spi_monitor: ADC frame model, frame-level reference model,
// table-driven vectors, randomized frames and a mid-frame reset sequence.
module tb_tsal_spi_monitor;
    localparam int AB = 12;
    localparam int FB = 16;
    localparam int CH = 2;
    localparam int HY = 16;
    localparam int BL = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AB-1:0] threshold = 12'h800;
    logic [CH*AB-1:0] sample;
    logic          sample_valid, hv_active, green_led, red_led;

    tsal_spi_if #(.CHANNELS(CH)) spi_bus ();

    tsal_spi_monitor dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi          (spi_bus.master),
        .threshold    (threshold),
        .sample       (sample),
        .sample_valid (sample_valid),
        .hv_active    (hv_active),
        .green_led    (green_led),
        .red_led      (red_led)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ADC model + reference model, evaluated on the falling clk edge.
    logic [FB-1:0] next_frame [CH];
    logic [FB-1:0] cur_frame  [CH];
    logic [FB-1:0] done_frame [CH];
    logic [AB-1:0] m_sample   [CH];
    bit            m_flag     [CH];
    bit            prev_cs, prev_sclk, commit_next, m_seen, m_hv, new_hv, exp_valid, exp_red;
    int            idx, cyc, onset, thr_done, r;

    initial begin
        for (int c = 0; c < CH; c++) next_frame[c] = '0;
        spi_bus.s_data = '0;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_cs = 1'b1; prev_sclk = 1'b1; commit_next = 1'b0;
            m_seen = 1'b0; m_hv = 1'b0; idx = 0; cyc = 0; onset = 0;
            for (int c = 0; c < CH; c++) begin m_flag[c] = 1'b0; m_sample[c] = '0; end
            chk("rst_cs", spi_bus.cs, 1);
            chk("rst_sclk", spi_bus.s_clk, 1);
            chk("rst_sample", sample, 0);
            chk("rst_valid", sample_valid, 0);
            chk("rst_hv", hv_active, 0);
            chk("rst_green", green_led, 0);
            chk("rst_red", red_led, 0);
        end else begin
            cyc++;
            // ADC side: next bit presented after each SCLK fall, MSB first.
            if (spi_bus.cs) idx = 0;
            else begin
                if (prev_cs) for (int c = 0; c < CH; c++) cur_frame[c] = next_frame[c];
                if (prev_sclk && !spi_bus.s_clk && idx < FB) begin
                    for (int c = 0; c < CH; c++) spi_bus.s_data[c] = cur_frame[c][FB-1-idx];
                    idx++;
                end
            end
            // Reference: result committed one cycle after cs rises.
            exp_valid = 1'b0;
            if (commit_next) begin
                commit_next = 1'b0;
                exp_valid = 1'b1;
                m_seen = 1'b1;
                for (int c = 0; c < CH; c++) begin
                    r = int'(done_frame[c] % (1 << AB));
                    m_sample[c] = AB'(r);
                    if (r >= thr_done) m_flag[c] = 1'b1;
                    else if (r + HY < thr_done) m_flag[c] = 1'b0;
                end
                new_hv = 1'b0;
                for (int c = 0; c < CH; c++) new_hv |= m_flag[c];
                if (new_hv && !m_hv) onset = cyc;
                m_hv = new_hv;
            end
            if (spi_bus.cs && !prev_cs) begin
                thr_done = int'(threshold);
                for (int c = 0; c < CH; c++) done_frame[c] = cur_frame[c];
                commit_next = 1'b1;
            end
            prev_cs = spi_bus.cs;
            prev_sclk = spi_bus.s_clk;
            exp_red = m_hv && (((cyc - onset) / BL) % 2 == 0);
            chk("valid", sample_valid, exp_valid);
            chk("sample", sample, {m_sample[1], m_sample[0]});
            chk("hv", hv_active, m_hv);
            chk("green", green_led, m_seen && !m_hv);
            chk("red", red_led, exp_red);
        end
    end

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (sample_valid) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_vec++; n_bad++;
            $display("FAIL valid_timeout: no sample_valid within 200 cycles at %0t", $time);
        end
    endtask

    typedef struct {
        logic [15:0] f0, f1;
        logic [11:0] thr;
        logic [11:0] s0, s1;
        logic        hv, green, red;
    } vec_t;
    vec_t tv [8];

    initial begin : main
        bit ok;
        int n, cycles, rises, first_rise, second_rise, tot, vcnt;
        bit prev;
        tv[0] = '{16'hF123, 16'h0456, 12'h800, 12'h123, 12'h456, 1'b0, 1'b1, 1'b0};
        tv[1] = '{16'h0800, 16'h0456, 12'h800, 12'h800, 12'h456, 1'b1, 1'b0, 1'b1};
        tv[2] = '{16'h07F1, 16'h0000, 12'h800, 12'h7F1, 12'h000, 1'b1, 1'b0, 1'b1};
        tv[3] = '{16'h07EF, 16'h0000, 12'h800, 12'h7EF, 12'h000, 1'b0, 1'b1, 1'b0};
        tv[4] = '{16'h0010, 16'h0000, 12'h008, 12'h010, 12'h000, 1'b1, 1'b0, 1'b1};
        tv[5] = '{16'h0000, 16'h0000, 12'h008, 12'h000, 12'h000, 1'b1, 1'b0, 1'b1};
        tv[6] = '{16'h0000, 16'h0FFF, 12'h800, 12'h000, 12'hFFF, 1'b1, 1'b0, 1'b0};
        tv[7] = '{16'h0000, 16'h0000, 12'h800, 12'h000, 12'h000, 1'b0, 1'b1, 1'b0};

        // Frame timing after reset release.
        repeat (3) @(posedge clk);
        @(posedge clk); #3 rst_n = 1'b1;
        n = 0;
        for (int i = 0; i < 20 && spi_bus.cs; i++) begin @(posedge clk); #1; n++; end
        chk("cs_fall_cycle", n, 4);
        cycles = 0; rises = 0; first_rise = -1; second_rise = -1; prev = spi_bus.s_clk;
        for (int i = 0; i < 200 && !spi_bus.cs; i++) begin
            @(posedge clk); #1; cycles++;
            if (!prev && spi_bus.s_clk) begin
                rises++;
                if (first_rise < 0) first_rise = cycles;
                else if (second_rise < 0) second_rise = cycles;
            end
            prev = spi_bus.s_clk;
        end
        chk("conv_cycles", cycles, 64);
        chk("sclk_rises", rises, 16);
        chk("sclk_first_rise", first_rise, 2);
        chk("sclk_period", second_rise - first_rise, 4);
        chk("sclk_idle_done", spi_bus.s_clk, 1);
        tot = cycles; vcnt = 0;
        for (int i = 0; i < 200 && spi_bus.cs; i++) begin
            @(posedge clk); #1; tot++;
            if (sample_valid) vcnt++;
        end
        chk("frame_period", tot, 69);
        chk("valid_pulses", vcnt, 1);
        wait_valid(ok);

        // Table-driven vectors on consecutive frames.
        for (int v = 0; v < 8; v++) begin
            next_frame[0] = tv[v].f0;
            next_frame[1] = tv[v].f1;
            threshold = tv[v].thr;
            wait_valid(ok);
            chk($sformatf("tv%0d_s0", v), sample[11:0], tv[v].s0);
            chk($sformatf("tv%0d_s1", v), sample[23:12], tv[v].s1);
            chk($sformatf("tv%0d_hv", v), hv_active, tv[v].hv);
            chk($sformatf("tv%0d_green", v), green_led, tv[v].green);
            chk($sformatf("tv%0d_red", v), red_led, tv[v].red);
        end

        // Randomized frames near the threshold, with mid-frame threshold changes.
        for (int k = 0; k < 40; k++) begin
            int thr, val;
            thr = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 16)) : int'($urandom_range(0, 4095));
            threshold = AB'(thr);
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 2) != 0) begin
                    val = thr + int'($urandom_range(0, 40)) - 20;
                    if (val < 0) val = 0;
                    if (val > 4095) val = 4095;
                end else val = int'($urandom_range(0, 4095));
                next_frame[c] = {4'($urandom_range(0, 15)), AB'(val)};
            end
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(10, 55)) @(posedge clk);
                #2 threshold = AB'($urandom_range(0, 4095));
            end
            wait_valid(ok);
        end

        // Reset asserted mid-frame, at SCLK bit 7.
        next_frame[0] = 16'h0ABC; next_frame[1] = 16'h0DEF;
        for (int i = 0; i < 200 && !spi_bus.cs; i++) begin @(posedge clk); #1; end
        for (int i = 0; i < 200 && spi_bus.cs; i++) begin @(posedge clk); #1; end
        rises = 0; prev = spi_bus.s_clk;
        for (int i = 0; i < 100 && rises < 7; i++) begin
            @(posedge clk); #1;
            if (!prev && spi_bus.s_clk) rises++;
            prev = spi_bus.s_clk;
        end
        chk("reset_at_bit7", rises, 7);
        rst_n = 1'b0;
        #1;
        chk("midrst_cs", spi_bus.cs, 1);
        chk("midrst_sclk", spi_bus.s_clk, 1);
        chk("midrst_green", green_led, 0);
        chk("midrst_red", red_led, 0);
        chk("midrst_sample", sample, 0);
        next_frame[0] = 16'h5123; next_frame[1] = 16'hA321;
        threshold = 12'h800;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        wait_valid(ok);
        chk("post_rst_s0", sample[11:0], 12'h123);
        chk("post_rst_s1", sample[23:12], 12'h321);
        chk("post_rst_green", green_led, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish within time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/tsal_spi_monitor.md
# tsal_spi_monitor

Parametrised successor to the single-channel TSAL threshold block. It continuously clocks CHANNELS SPI ADCs in lock-step over a shared `cs`/`s_clk` pair and captures an ADC_BITS result from each. Each channel's result is compared against a programmable threshold with hysteresis. The block drives the TSAL lamps: green steady when every channel is verified safe, red flashing while any channel reads high voltage.

## Interface
Parameters:
- ADC_BITS, 12, result width per channel; also the width of `threshold`
- FRAME_BITS, 16, SCLK cycles per conversion frame; must be ≥ ADC_BITS
- CHANNELS, 2, number of ADCs / `s_data` lines
- CLK_DIV, 2, `clk` cycles per SCLK half-period; must be ≥ 1
- QUIET_CYC, 4, `clk` cycles `cs` stays high between frames; must be ≥ 1
- HYST, 16, hysteresis in LSBs
- BLINK_DIV, 8, `clk` cycles per red-lamp toggle; must be ≥ 1

Ports:
- clk  in  1  system clock. One clock domain only.
- rst_n  in  1  reset, asynchronous assert, active-low
- s_data  in  CHANNELS  serial data, one bit per ADC
- threshold  in  ADC_BITS  HV threshold, unsigned
- s_clk  out  1  SPI clock, idle high
- cs  out  1  chip select, active-low
- sample  out  CHANNELS*ADC_BITS  latest results; channel i occupies bits [i*ADC_BITS +: ADC_BITS]
- sample_valid  out  1  one-cycle pulse when `sample` updates
- hv_active  out  1  OR of the per-channel HV flags
- green_led  out  1  safe indication
- red_led  out  1  HV indication, flashing

## Operation
- Reset values: `cs`=1, `s_clk`=1, `sample`=0, `sample_valid`=0, all HV flags and `hv_active`=0, `green_led`=0, `red_led`=0, blink counter=0, `seen`=0.
- FSM states:
  - QUIET: `cs`=1 for QUIET_CYC cycles, then go to CONV.
  - CONV: `cs`=0 for FRAME_BITS SCLK cycles. Each SCLK cycle is CLK_DIV cycles low, then CLK_DIV cycles high. When the frame completes, go to DONE.
  - DONE: one cycle, `cs`=1. Commit the sample, then go to QUIET.
- Reset exits into QUIET.
- Sampling: on the `clk` edge that drives `s_clk` 0→1, each `s_data[i]` shifts MSB-first into that channel's shift register.
- Result: after FRAME_BITS bits, the result is the last ADC_BITS bits shifted in. The leading FRAME_BITS−ADC_BITS bits are discarded.
- DONE cycle:
  - `sample` loads from the shift registers.
  - `sample_valid`=1.
  - `seen` is set.
  - HV flags update, with `threshold` sampled in this same cycle.
- Hysteresis, per channel, evaluated at DONE:
  - If the result ≥ `threshold`, set the flag.
  - Else if result + HYST < `threshold`, clear the flag. This sum is computed in ADC_BITS+1 bits and never wraps.
  - Otherwise hold the flag.
  - If `threshold` ≤ HYST, a set flag never clears except by reset.
- Lamps:
  - `green_led` = `seen` & ~`hv_active`.
  - While `hv_active`=0: `red_led`=0 and the blink counter is held at 0.
  - On a 0→1 change of `hv_active`: `red_led` goes 1 in the same cycle the flag registers. It then toggles every BLINK_DIV cycles.
  - `green_led` and `red_led` are never 1 together.
- `threshold` changes mid-frame take effect only at the next DONE.

## Timing
- Frame period = 2·CLK_DIV·FRAME_BITS + 1 + QUIET_CYC cycles. This is 69 cycles at the default parameters.
- First `cs` fall occurs QUIET_CYC cycles after `rst_n` is released.
- `s_data` must be stable for at least one `clk` cycle before the `s_clk` rising edge.
- `sample`, `hv_active`, `green_led` and the red onset are all registered in the DONE cycle. They become visible together, in the cycle `sample_valid` is high.
- Reset mid-frame: all outputs return to their reset values immediately (asynchronous). The partial frame is discarded and no `sample_valid` is produced for it.

## Test plan
Defaults throughout; `threshold`=0x800.
- Reset release → `cs` falls at cycle 4; 16 SCLK pulses of 4 cycles each; `cs` rises; `sample_valid` pulses once; next `cs` fall is 69 cycles after the first.
- ch0 frame 0xF123, ch1 frame 0x0456 → `sample`={0x456,0x123}; `hv_active`=0; `green_led`=1; `red_led`=0.
- ch0 result 0x800 → `hv_active`=1 and `red_led`=1 in the valid cycle; `red_led` toggles every 8 cycles; `green_led`=0.
- Hysteresis on ch0, starting from HV set: result 0x7F1 → flag held; next result 0x7EF → flag cleared, `green_led`=1, `red_led`=0.
- `threshold`=0x008 (≤ HYST) and result 0x010 → flag set; a following result of 0x000 leaves the flag set.
- Assert `rst_n` mid-frame at bit 7 → `cs`=1, `s_clk`=1, both LEDs 0 immediately; after release, the first `sample` reflects only the new frame.
